glitc_dedisperse_fir: RTL and testbench
=======================================

Name: glitc_dedisperse_fir

Overview:
Parametrised, pipelined FIR dedispersion filter for the GLITC trigger path. It replaces the pass-through dedisperse stage: input is one demultiplexed word of DEMUX samples per clock, output is a requantised filtered word of the same format. Tap coefficients are runtime-loadable through a double-buffered write port. The stage has a latency-matched bypass mode.

Parameters:
NBITS, 3, bits per sample (unsigned offset code)
DEMUX, 16, samples per clock word
NTAPS, 8, FIR taps, 1..2*DEMUX
COEFF_BITS, 4, signed two's-complement coefficient width
SHIFT, 2, arithmetic right shift applied to the accumulator before requantisation

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset
raw_i  in  DEMUX*NBITS  input word; sample i at [i*NBITS +: NBITS]; index 0 oldest
filter_o  out  DEMUX*NBITS  filtered word, same packing
valid_o  out  1  filter_o holds fully primed data
mode_i  in  1  0 = bypass, 1 = filter
coef_wr_i  in  1  write strobe, shadow bank
coef_addr_i  in  clog2(NTAPS)  tap index
coef_dat_i  in  COEFF_BITS  coefficient value
coef_commit_i  in  1  copy shadow bank to active bank
sat_o  out  1  one or more samples in the current filter_o word saturated
sat_count_o  out  16  saturating count of words with sat_o=1

Behaviour:
- One clock, clk_i. Reset is asynchronous, active-low (rst_n_i).
- Reset values:
  - filter_o: every sample = 2^(NBITS-1) (code 4).
  - valid_o, sat_o, sat_count_o: 0.
  - History registers: all samples = 2^(NBITS-1).
  - Active and shadow banks: identity (c0 = 2^SHIFT, all other taps 0).
- Sample arithmetic:
  - Signed value x' = code - 2^(NBITS-1), range -4..3 at the default.
  - Stream index n = word*DEMUX + i.
  - y[n] = sum over k=0..NTAPS-1 of c_k * x'[n-k].
  - Taps with n-k < word*DEMUX read from history.
  - History depth HIST = ceil((NTAPS-1)/DEMUX) previous words.
- Widths:
  - Accumulator is signed, ACCW = NBITS + COEFF_BITS + clog2(NTAPS) + 1. It never overflows.
  - Output code = clamp((acc >>> SHIFT) + 2^(NBITS-1), 0, 2^NBITS - 1). The shift floors toward -inf.
  - A sample is saturated when the clamp engages.
- Pipeline, fixed latency 2 clocks from a raw_i edge to filter_o:
  - Stage 1 registers all products using the active bank.
  - Stage 2 registers the sum, the requantised output and sat_o.
- Every output word uses exactly one coefficient bank. No output mixes banks.
- Bypass (mode_i=0):
  - filter_o = raw_i delayed by the same 2 clocks.
  - sat_o = 0.
  - History keeps updating.
  - mode_i is sampled at stage 1 and travels with its data, so toggling never produces a glitch word.
- valid_o:
  - Low for HIST+2 clocks after reset release, high afterwards until the next reset.
  - It is independent of mode_i.
- Coefficient port:
  - coef_wr_i writes coef_dat_i into shadow[coef_addr_i] on the clock edge.
  - Writes with addr >= NTAPS are ignored.
  - The active bank is unaffected by writes.
  - coef_commit_i copies the shadow bank to the active bank on the edge it is sampled high. Words entering stage 1 on the following edge use the new bank, so the first affected output appears 2 clocks after the commit edge.
  - Write and commit in the same cycle: the write is included in the committed bank.
  - Repeated commits with no intervening writes have no effect.
- sat_count_o increments on each clock with sat_o=1 and holds at 0xFFFF.
- Reset mid-operation: all state returns to the reset values immediately, including the coefficient banks.

Test Plan:
- Identity (reset coefficients), mode_i=1, ramp codes 0..7 repeating -> filter_o equals raw_i exactly 2 clocks later; sat_o=0; valid_o rises on the (HIST+2)th clock after reset release.
- Write c0=0, c1=4, commit; steady words -> each output sample equals the previous input sample. Output sample 0 takes the input's sample 15 from the prior word (word-boundary check).
- c0=7, input all code 7 (x'=3) -> acc=21, 21>>>2=5, 5+4=9 clamps to 7; sat_o=1 for that word; sat_count_o increments once per word. Input all code 0 -> clamps to 0.
- Commit asserted mid-stream alongside a same-cycle write -> outputs switch bank exactly 2 clocks after the commit edge; no mixed word; the same-cycle write is present in the new bank.
- Toggle mode_i every 3 clocks with random data -> bypass words equal raw_i delayed 2 clocks; filter words match the reference model; no dropped or duplicated words.
- Assert rst_n_i asynchronously mid-stream -> filter_o goes to all code 4, valid_o=0 and sat_count_o=0 without waiting for a clock edge; coefficients return to identity.

Source files
------------

// File: rtl/glitc_dedisperse_fir.sv
// glitc_dedisperse_fir
// Pipelined FIR dedispersion stage for the GLITC trigger path. One word of
// DEMUX unsigned offset-coded samples enters per clock. Each sample is
// convolved with a runtime-loadable tap set, requantised and clamped. Output
// arrives two clocks later. Bypass mode delays the raw word through the same
// two registers, so switching modes never changes latency.
module glitc_dedisperse_fir #(
    parameter int NBITS      = 3,
    parameter int DEMUX      = 16,
    parameter int NTAPS      = 8,
    parameter int COEFF_BITS = 4,
    parameter int SHIFT      = 2
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic [DEMUX*NBITS-1:0]                       raw_i,
    output logic [DEMUX*NBITS-1:0]                       filter_o,
    output logic                                         valid_o,
    input  logic                                         mode_i,
    input  logic                                         coef_wr_i,
    input  logic [((NTAPS > 1) ? $clog2(NTAPS) : 1)-1:0] coef_addr_i,
    input  logic [COEFF_BITS-1:0]                        coef_dat_i,
    input  logic                                         coef_commit_i,
    output logic                                         sat_o,
    output logic [15:0]                                  sat_count_o
);

    localparam int W     = DEMUX * NBITS;
    // Words of history needed to reach back NTAPS-1 samples; this sets how
    // long the output must wait before it is fully primed.
    localparam int HIST  = (NTAPS - 1 + DEMUX - 1) / DEMUX;
    // Only the most recent NTAPS-1 samples of that history are ever read, so
    // only those are stored.
    localparam int HSW   = (NTAPS > 1) ? (NTAPS - 1) : 1;
    localparam int EXTN  = DEMUX + HSW;
    localparam int PW    = NBITS + COEFF_BITS;
    localparam int ACCW  = NBITS + COEFF_BITS + $clog2(NTAPS) + 1;
    localparam int VDONE = HIST + 2;
    localparam int VCW   = $clog2(VDONE + 1);

    localparam logic [NBITS-1:0]             MID   = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic signed [COEFF_BITS-1:0] C0    = COEFF_BITS'(1 << SHIFT);
    localparam logic signed [ACCW-1:0]       HALF  = ACCW'(1 << (NBITS - 1));
    localparam logic signed [ACCW-1:0]       MAXC  = ACCW'((1 << NBITS) - 1);

    // Coefficient banks
    logic signed [COEFF_BITS-1:0] shadCoef_q [NTAPS];
    logic signed [COEFF_BITS-1:0] shadCoef_d [NTAPS];
    logic signed [COEFF_BITS-1:0] actCoef_q  [NTAPS];

    // Stage 1: history, products, bypass copy and mode tag
    logic [HSW*NBITS-1:0]  hist_q;
    logic [EXTN*NBITS-1:0] ext;
    logic signed [PW-1:0]  prod_q [DEMUX][NTAPS];
    logic signed [PW-1:0]  prod_d [DEMUX][NTAPS];
    logic [W-1:0]          rawDly_q;
    logic                  mode_q;

    // Stage 2: accumulate, requantise, saturation status
    logic signed [ACCW-1:0] acc_d [DEMUX];
    logic [W-1:0]           filt_d;
    logic [DEMUX-1:0]       satVec_d;
    logic [W-1:0]           filter_q;
    logic                   sat_q;
    logic [15:0]            satCount_q;
    logic [VCW-1:0]         validCnt_q;
    logic                   valid_q;

    // Stream-ordered view: stored history samples first (oldest at index 0),
    // then the current word.
    assign ext = {raw_i, hist_q};

    // Convert an offset code to signed and multiply by one tap coefficient.
    function automatic logic signed [PW-1:0] mulTap(
        input logic [NBITS-1:0]             code,
        input logic signed [COEFF_BITS-1:0] coef
    );
        logic signed [NBITS-1:0] xs;
        logic signed [PW-1:0]    a;
        logic signed [PW-1:0]    b;
        xs = code ^ MID;
        a  = PW'(xs);
        b  = PW'(coef);
        return a * b;
    endfunction

    // Floor-shift the accumulator, re-add the offset and clamp; MSB of the
    // result flags that the clamp engaged.
    function automatic logic [NBITS:0] requant(input logic signed [ACCW-1:0] acc);
        logic signed [ACCW-1:0] t;
        t = (acc >>> SHIFT) + HALF;
        if (t < 0) begin
            return {1'b1, {NBITS{1'b0}}};
        end
        if (t > MAXC) begin
            return {1'b1, {NBITS{1'b1}}};
        end
        return {1'b0, t[NBITS-1:0]};
    endfunction

    // Shadow-bank next state: an in-range write lands here, so a same-cycle commit sees it.
    always_comb begin
        shadCoef_d = shadCoef_q;
        if (coef_wr_i && (int'(coef_addr_i) < NTAPS)) begin
            shadCoef_d[coef_addr_i] = coef_dat_i;
        end
    end

    // Bank registers: writes touch only the shadow, a commit copies it to the active bank.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadCoef_q[k] <= (k == 0) ? C0 : '0;
                actCoef_q[k]  <= (k == 0) ? C0 : '0;
            end
        end else begin
            shadCoef_q <= shadCoef_d;
            if (coef_commit_i) begin
                actCoef_q <= shadCoef_d;
            end
        end
    end

    // All products of every sample against every tap, using the active bank only.
    always_comb begin
        for (int i = 0; i < DEMUX; i++) begin
            for (int k = 0; k < NTAPS; k++) begin
                prod_d[i][k] = mulTap(ext[(HSW + i - k)*NBITS +: NBITS], actCoef_q[k]);
            end
        end
    end

    // Stage 1 register: products, raw copy for bypass, mode tag and sample history.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hist_q   <= {HSW{MID}};
            rawDly_q <= {DEMUX{MID}};
            mode_q   <= 1'b0;
            prod_q   <= '{default: '0};
        end else begin
            hist_q   <= ext[EXTN*NBITS-1 -: HSW*NBITS];
            rawDly_q <= raw_i;
            mode_q   <= mode_i;
            prod_q   <= prod_d;
        end
    end

    // Sum the registered products for each output sample.
    always_comb begin
        for (int i = 0; i < DEMUX; i++) begin
            acc_d[i] = '0;
            for (int k = 0; k < NTAPS; k++) begin
                acc_d[i] = acc_d[i] + ACCW'(prod_q[i][k]);
            end
        end
    end

    // Requantise each sum back to an offset code and collect clamp flags.
    always_comb begin
        filt_d   = '0;
        satVec_d = '0;
        for (int i = 0; i < DEMUX; i++) begin
            {satVec_d[i], filt_d[i*NBITS +: NBITS]} = requant(acc_d[i]);
        end
    end

    // Stage 2 register: the mode tag picked up in stage 1 chooses filtered or raw data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            filter_q <= {DEMUX{MID}};
            sat_q    <= 1'b0;
        end else begin
            filter_q <= mode_q ? filt_d : rawDly_q;
            sat_q    <= mode_q & (|satVec_d);
        end
    end

    // Saturating count of clocks on which sat_o was high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            satCount_q <= '0;
        end else if (sat_q && (satCount_q != 16'hFFFF)) begin
            satCount_q <= satCount_q + 16'd1;
        end
    end

    // Priming counter: valid_o rises on the (HIST+2)th clock after reset release and stays high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            validCnt_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            if (validCnt_q != VCW'(VDONE)) begin
                validCnt_q <= validCnt_q + VCW'(1);
            end
            valid_q <= valid_q | (validCnt_q == VCW'(VDONE - 1));
        end
    end

    assign filter_o    = filter_q;
    assign sat_o       = sat_q;
    assign sat_count_o = satCount_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_glitc_dedisperse_fir.sv
// Testbench for glitc_dedisperse_fir at default parameters. Every driven word
// pushes its expected output (from an integer reference model) onto a
// scoreboard queue; entries are popped when the DUT presents that word.
module tb_glitc_dedisperse_fir;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [47:0] raw_i = '0;
    logic [47:0] filter_o;
    logic        valid_o;
    logic        mode_i = 1'b1;
    logic        coef_wr_i = 1'b0;
    logic [2:0]  coef_addr_i = '0;
    logic [3:0]  coef_dat_i = '0;
    logic        coef_commit_i = 1'b0;
    logic        sat_o;
    logic [15:0] sat_count_o;

    typedef struct {
        logic [47:0] word;
        logic        sat;
        logic [2:0]  prevLast;
        logic        isDelay;
    } exp_t;

    exp_t        sbq[$];
    int          modelAct[8];
    int          modelShad[8];
    logic [47:0] prevWord;
    int          expCount;
    int          total = 0;
    int          bad = 0;
    logic [47:0] allMid;

    glitc_dedisperse_fir dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .raw_i(raw_i), .filter_o(filter_o),
        .valid_o(valid_o), .mode_i(mode_i), .coef_wr_i(coef_wr_i),
        .coef_addr_i(coef_addr_i), .coef_dat_i(coef_dat_i),
        .coef_commit_i(coef_commit_i), .sat_o(sat_o), .sat_count_o(sat_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [47:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    // Integer reference: y[n] = sum c_k * (code[n-k]-4), floor >>>2, +4, clamp 0..7.
    function automatic void model_word(input logic [47:0] raw, input logic m,
                                       output logic [47:0] y, output logic s);
        int acc, t, idx;
        logic [2:0] code;
        y = raw;
        s = 1'b0;
        if (!m) return;
        for (int i = 0; i < 16; i++) begin
            acc = 0;
            for (int k = 0; k < 8; k++) begin
                idx = i - k;
                code = (idx >= 0) ? raw[idx*3 +: 3] : prevWord[(idx+16)*3 +: 3];
                acc += modelAct[k] * (int'(code) - 4);
            end
            t = (acc >>> 2) + 4;
            if (t < 0) begin t = 0; s = 1'b1; end
            else if (t > 7) begin t = 7; s = 1'b1; end
            y[i*3 +: 3] = 3'(t);
        end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            modelAct[k]  = (k == 0) ? 4 : 0;
            modelShad[k] = (k == 0) ? 4 : 0;
        end
        prevWord = allMid;
        expCount = 0;
        sbq.delete();
    endtask

    task automatic drive_word(input logic [47:0] raw, input logic m,
                              input logic wr = 1'b0, input logic [2:0] addr = 3'd0,
                              input logic [3:0] dat = 4'd0, input logic commit = 1'b0);
        exp_t e;
        raw_i = raw; mode_i = m; coef_wr_i = wr; coef_addr_i = addr;
        coef_dat_i = dat; coef_commit_i = commit;
        model_word(raw, m, e.word, e.sat);
        e.prevLast = prevWord[47:45];
        e.isDelay = m && (modelAct[0] == 0) && (modelAct[1] == 4);
        for (int k = 2; k < 8; k++) if (modelAct[k] != 0) e.isDelay = 1'b0;
        sbq.push_back(e);
        prevWord = raw;
        if (wr) modelShad[addr] = int'(signed'(dat));
        if (commit) modelAct = modelShad;
    endtask

    // Advance one clock and pop the entry the DUT is now presenting, if any.
    task automatic tick_pop(output logic got, output exp_t e, output int cntBefore);
        @(posedge clk_i);
        #1;
        got = 1'b0;
        cntBefore = expCount;
        if (sbq.size() >= 2) begin
            e = sbq.pop_front();
            got = 1'b1;
            if (e.sat && expCount < 65535) expCount++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        #1;
        total++; if (filter_o !== allMid) begin bad++; $display("[TB] FAIL reset filter: got %h expected %h", filter_o, allMid); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset valid: got %b expected 0", valid_o); end
        total++; if (sat_o !== 1'b0) begin bad++; $display("[TB] FAIL reset sat: got %b expected 0", sat_o); end
        total++; if (sat_count_o !== 16'd0) begin bad++; $display("[TB] FAIL reset satcount: got %0d expected 0", sat_count_o); end
        model_reset();
        rst_n_i = 1'b1;
    endtask

    task automatic test_identity();
        logic got; exp_t e; int c; logic [47:0] w;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < 16; i++) w[i*3 +: 3] = 3'((n*16 + i) % 8);
            drive_word(w, 1'b1);
            tick_pop(got, e, c);
            total++; if (valid_o !== (n + 1 >= 3)) begin bad++; $display("[TB] FAIL ident valid edge %0d: got %b expected %b", n + 1, valid_o, (n + 1 >= 3)); end
            if (got) begin
                total++; if (filter_o !== e.word) begin bad++; $display("[TB] FAIL ident word: got %h expected %h", filter_o, e.word); end
                total++; if (sat_o !== e.sat) begin bad++; $display("[TB] FAIL ident sat: got %b expected %b", sat_o, e.sat); end
            end
        end
    endtask

    task automatic test_delay_tap();
        logic got; exp_t e; int c;
        for (int n = 0; n < 10; n++) begin
            if (n == 0) drive_word(rand_word(), 1'b1, 1'b1, 3'd0, 4'd0, 1'b0);
            else if (n == 1) drive_word(rand_word(), 1'b1, 1'b1, 3'd1, 4'd4, 1'b1);
            else drive_word(rand_word(), 1'b1);
            tick_pop(got, e, c);
            if (got) begin
                total++; if (filter_o !== e.word) begin bad++; $display("[TB] FAIL delay word: got %h expected %h", filter_o, e.word); end
                if (e.isDelay) begin
                    total++; if (filter_o[2:0] !== e.prevLast) begin bad++; $display("[TB] FAIL delay boundary: got %0d expected %0d", filter_o[2:0], e.prevLast); end
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic got; exp_t e; int c; logic [47:0] w;
        for (int n = 0; n < 12; n++) begin
            w = (n < 6) ? {16{3'd7}} : {16{3'd0}};
            if (n == 0) drive_word(w, 1'b1, 1'b1, 3'd0, 4'd7, 1'b0);
            else if (n == 1) drive_word(w, 1'b1, 1'b1, 3'd1, 4'd0, 1'b1);
            else drive_word(w, 1'b1);
            tick_pop(got, e, c);
            if (got) begin
                total++; if (filter_o !== e.word) begin bad++; $display("[TB] FAIL sat word: got %h expected %h", filter_o, e.word); end
                total++; if (sat_o !== e.sat) begin bad++; $display("[TB] FAIL sat flag: got %b expected %b", sat_o, e.sat); end
                total++; if (sat_count_o !== 16'(c)) begin bad++; $display("[TB] FAIL sat count: got %0d expected %0d", sat_count_o, c); end
            end
        end
    endtask

    task automatic test_commit();
        logic got; exp_t e; int c;
        for (int n = 0; n < 12; n++) begin
            if (n == 3) drive_word(rand_word(), 1'b1, 1'b1, 3'd0, 4'd4, 1'b0);
            else if (n == 6) drive_word(rand_word(), 1'b1, 1'b1, 3'd3, 4'hE, 1'b1);
            else if (n == 8) drive_word(rand_word(), 1'b1, 1'b0, 3'd0, 4'd0, 1'b1);
            else drive_word(rand_word(), 1'b1);
            tick_pop(got, e, c);
            if (got) begin
                total++; if (filter_o !== e.word) begin bad++; $display("[TB] FAIL commit word: got %h expected %h", filter_o, e.word); end
                total++; if (sat_o !== e.sat) begin bad++; $display("[TB] FAIL commit sat: got %b expected %b", sat_o, e.sat); end
                total++; if (sat_count_o !== 16'(c)) begin bad++; $display("[TB] FAIL commit count: got %0d expected %0d", sat_count_o, c); end
            end
        end
    endtask

    task automatic test_mode_toggle();
        logic got; exp_t e; int c;
        for (int n = 0; n < 24; n++) begin
            drive_word(rand_word(), ((n / 3) % 2) == 1);
            tick_pop(got, e, c);
            if (got) begin
                total++; if (filter_o !== e.word) begin bad++; $display("[TB] FAIL mode word: got %h expected %h", filter_o, e.word); end
                total++; if (sat_o !== e.sat) begin bad++; $display("[TB] FAIL mode sat: got %b expected %b", sat_o, e.sat); end
                total++; if (valid_o !== 1'b1) begin bad++; $display("[TB] FAIL mode valid: got %b expected 1", valid_o); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic got; exp_t e; int c;
        drive_word(rand_word(), 1'b1);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        total++; if (filter_o !== allMid) begin bad++; $display("[TB] FAIL async filter: got %h expected %h", filter_o, allMid); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL async valid: got %b expected 0", valid_o); end
        total++; if (sat_count_o !== 16'd0) begin bad++; $display("[TB] FAIL async satcount: got %0d expected 0", sat_count_o); end
        total++; if (sat_o !== 1'b0) begin bad++; $display("[TB] FAIL async sat: got %b expected 0", sat_o); end
        model_reset();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        for (int n = 0; n < 8; n++) begin
            drive_word(rand_word(), 1'b1);
            tick_pop(got, e, c);
            total++; if (valid_o !== (n + 1 >= 3)) begin bad++; $display("[TB] FAIL post-reset valid edge %0d: got %b expected %b", n + 1, valid_o, (n + 1 >= 3)); end
            if (got) begin
                total++; if (filter_o !== e.word) begin bad++; $display("[TB] FAIL post-reset word: got %h expected %h", filter_o, e.word); end
            end
        end
    endtask

    initial begin
        allMid = {16{3'd4}};
        raw_i = allMid;
        test_reset();
        test_identity();
        test_delay_tap();
        test_saturation();
        test_commit();
        test_mode_toggle();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
